// File: rtl/maze_pkg.sv
// Shared types for the 16x16 maze depth-first sequencer: location layout, directions, FSM states.
package maze_pkg;

    localparam int unsigned LOC_W = 8;
    localparam int unsigned ROW_W = 4;
    localparam int unsigned COL_W = 4;
    localparam int unsigned DIR_W = 2;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } locT;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dirT;

    typedef enum logic [3:0] {
        IDLE,
        FLUSH,
        MARK,
        PROBE,
        WAIT,
        NEXT,
        BACK,
        POPW,
        DONE,
        FAIL
    } stateT;

endpackage

// File: rtl/maze_dfs_ctrl_nbr_calc.sv
// Neighbour of a cell in a given direction, with a grid bounds check (combinational).
module maze_nbr_calc
    import maze_pkg::*;
(
    input  locT  loc,
    input  dirT  dir,
    output locT  nbr_loc,
    output logic nbr_valid
);

    always_comb begin
        nbr_loc   = loc;
        nbr_valid = 1'b0;
        case (dir)
            DIR_UP: begin
                nbr_loc.row = loc.row - ROW_W'(1);
                nbr_valid   = (loc.row != '0);
            end
            DIR_RIGHT: begin
                nbr_loc.col = loc.col + COL_W'(1);
                nbr_valid   = (loc.col != '1);
            end
            DIR_DOWN: begin
                nbr_loc.row = loc.row + ROW_W'(1);
                nbr_valid   = (loc.row != '1);
            end
            DIR_LEFT: begin
                nbr_loc.col = loc.col - COL_W'(1);
                nbr_valid   = (loc.col != '0);
            end
        endcase
    end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze-solver sequencer driving maze RAM and location stack.
// Optional move counter on the steps port is built when MAZE_STEP_CNT_EN is defined.
module maze_dfs_ctrl
    import maze_pkg::*;
#(
    parameter logic [LOC_W-1:0] START_LOC = 8'h00,
    parameter logic [LOC_W-1:0] GOAL_LOC  = 8'hFF,
    parameter int unsigned      MAX_DEPTH = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [LOC_W-1:0] mem_addr,
    output logic             mem_rd,
    input  logic             mem_rdata,
    output logic             mem_wr,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [LOC_W-1:0] stk_din,
    input  logic [LOC_W-1:0] stk_dout,
    input  logic             stk_nempty,
    output logic [LOC_W-1:0] cur_loc,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             ovf,
    output logic [15:0]      steps
);

    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

    stateT              state, stateNext;
    dirT                dir, dirNext;
    logic [DEPTH_W-1:0] depth, depthNext;
    logic [LOC_W-1:0]   locNext;
    logic               doneNext, failNext, ovfNext, busyNext;
    locT                nbrLoc;
    logic               nbrValid;

    maze_nbr_calc uNbr (
        .loc       (locT'(cur_loc)),
        .dir       (dir),
        .nbr_loc   (nbrLoc),
        .nbr_valid (nbrValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= DIR_UP;
            depth   <= '0;
            cur_loc <= START_LOC;
            done    <= 1'b0;
            fail    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= stateNext;
            dir     <= dirNext;
            depth   <= depthNext;
            cur_loc <= locNext;
            done    <= doneNext;
            fail    <= failNext;
            ovf     <= ovfNext;
            busy    <= busyNext;
        end
    end

    // RAM and stack strobes are decoded in the same cycle the FSM acts on them.
    always_comb begin
        stateNext = state;
        dirNext   = dir;
        depthNext = depth;
        locNext   = cur_loc;
        doneNext  = done;
        failNext  = fail;
        ovfNext   = ovf;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    doneNext  = 1'b0;
                    failNext  = 1'b0;
                    ovfNext   = 1'b0;
                    locNext   = START_LOC;
                    dirNext   = DIR_UP;
                    depthNext = '0;
                    stateNext = stk_nempty ? FLUSH : MARK;
                end
            end
            FLUSH: begin
                if (stk_nempty) stk_pop = 1'b1;
                else            stateNext = MARK;
            end
            MARK: begin
                mem_wr   = 1'b1;
                mem_addr = cur_loc;
                if (cur_loc == GOAL_LOC) begin
                    doneNext  = 1'b1;
                    stateNext = DONE;
                end else begin
                    stateNext = PROBE;
                end
            end
            PROBE: begin
                if (nbrValid) begin
                    mem_rd    = 1'b1;
                    mem_addr  = nbrLoc;
                    stateNext = WAIT;
                end else begin
                    stateNext = NEXT;
                end
            end
            WAIT: begin
                if (mem_rdata) begin
                    stateNext = NEXT;
                end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
                    failNext  = 1'b1;
                    ovfNext   = 1'b1;
                    stateNext = FAIL;
                end else begin
                    stk_push  = 1'b1;
                    stk_din   = cur_loc;
                    depthNext = depth + DEPTH_W'(1);
                    locNext   = nbrLoc;
                    dirNext   = DIR_UP;
                    stateNext = MARK;
                end
            end
            NEXT: begin
                if (dir == DIR_LEFT) begin
                    stateNext = BACK;
                end else begin
                    dirNext   = dirT'(dir + 2'd1);
                    stateNext = PROBE;
                end
            end
            BACK: begin
                if (stk_nempty) begin
                    stk_pop   = 1'b1;
                    depthNext = depth - DEPTH_W'(1);
                    stateNext = POPW;
                end else begin
                    failNext  = 1'b1;
                    stateNext = FAIL;
                end
            end
            POPW: begin
                locNext   = stk_dout;
                dirNext   = DIR_UP;
                stateNext = PROBE;
            end
            default: stateNext = IDLE;
        endcase
        busyNext = !(stateNext inside {IDLE, DONE, FAIL});
    end

`ifdef MAZE_STEP_CNT_EN
    logic clrSteps, stepInc;

    // Forward moves and backtrack pops count; flush pops do not.
    assign clrSteps = start && (state inside {IDLE, DONE, FAIL});
    assign stepInc  = stk_push || (stk_pop && (state == BACK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           steps <= '0;
        else if (clrSteps)                 steps <= '0;
        else if (stepInc && steps != '1)   steps <= steps + 16'd1;
    end
`else
    assign steps = 16'h0000;
`endif

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Directed bench for maze_dfs_ctrl: two instances (goal 03 / depth 4, and goal 11) with RAM and stack models.
module tb_maze_dfs_ctrl;

`ifdef MAZE_STEP_CNT_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: GOAL_LOC = 03, MAX_DEPTH = 4
    logic       startA = 1'b0;
    logic [7:0] addrA, dinA, stkDinA, curA, tbDinA = '0;
    logic       rdA, wrA, pushA, popA, busyA, doneA, failA, ovfA, tbPushA = 1'b0;
    logic [15:0] stepsA;
    logic       rdataA = 1'b0;
    logic [7:0] stkDoutA = '0;
    logic       wallA [256];
    logic       visA [256];
    logic       clrVisA = 1'b0, clrCntA = 1'b0;
    logic [7:0] stkA [64];
    int         spA = 0, pushCntA = 0, popCntA = 0, popsAtWrA = 0, violA = 0;
    logic       firstWrA = 1'b0;
    logic [7:0] wrAddrA = '0;

    // Instance B: GOAL_LOC = 11, default depth
    logic       startB = 1'b0;
    logic [7:0] addrB, stkDinB, curB;
    logic       rdB, wrB, pushB, popB, busyB, doneB, failB, ovfB;
    logic [15:0] stepsB;
    logic       rdataB = 1'b0;
    logic [7:0] stkDoutB = '0;
    logic       wallB [256];
    logic       visB [256];
    logic       clrVisB = 1'b0, clrCntB = 1'b0;
    logic [7:0] stkB [64];
    int         spB = 0, pushCntB = 0, popCntB = 0, violB = 0;

    assign dinA = tbPushA ? tbDinA : stkDinA;

    maze_dfs_ctrl #(.GOAL_LOC(8'h03), .MAX_DEPTH(4)) uA (
        .clk(clk), .rst(rst), .start(startA),
        .mem_addr(addrA), .mem_rd(rdA), .mem_rdata(rdataA), .mem_wr(wrA),
        .stk_push(pushA), .stk_pop(popA), .stk_din(stkDinA), .stk_dout(stkDoutA),
        .stk_nempty(spA != 0), .cur_loc(curA), .busy(busyA), .done(doneA),
        .fail(failA), .ovf(ovfA), .steps(stepsA)
    );

    maze_dfs_ctrl #(.GOAL_LOC(8'h11)) uB (
        .clk(clk), .rst(rst), .start(startB),
        .mem_addr(addrB), .mem_rd(rdB), .mem_rdata(rdataB), .mem_wr(wrB),
        .stk_push(pushB), .stk_pop(popB), .stk_din(stkDinB), .stk_dout(stkDoutB),
        .stk_nempty(spB != 0), .cur_loc(curB), .busy(busyB), .done(doneB),
        .fail(failB), .ovf(ovfB), .steps(stepsB)
    );

    // Stack models share rst with the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spA <= 0;
            stkDoutA <= '0;
        end else if (pushA || tbPushA) begin
            stkA[spA] <= dinA;
            spA <= spA + 1;
        end else if (popA && spA > 0) begin
            stkDoutA <= stkA[spA-1];
            spA <= spA - 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spB <= 0;
            stkDoutB <= '0;
        end else if (pushB) begin
            stkB[spB] <= stkDinB;
            spB <= spB + 1;
        end else if (popB && spB > 0) begin
            stkDoutB <= stkB[spB-1];
            spB <= spB - 1;
        end
    end

    // Maze RAM models plus transaction counters
    always @(posedge clk) begin
        if (clrVisA) for (int i = 0; i < 256; i++) visA[i] <= 1'b0;
        else if (wrA) visA[addrA] <= 1'b1;
        if (rdA) rdataA <= wallA[addrA] | visA[addrA];
        if ((pushA && popA) || (rdA && wrA)) violA <= violA + 1;
        if (clrCntA) begin
            pushCntA <= 0; popCntA <= 0; popsAtWrA <= 0; firstWrA <= 1'b0; wrAddrA <= '0;
        end else begin
            if (pushA) pushCntA <= pushCntA + 1;
            if (popA) popCntA <= popCntA + 1;
            if (wrA && !firstWrA) begin
                firstWrA <= 1'b1;
                popsAtWrA <= popCntA;
                wrAddrA <= addrA;
            end
        end
    end

    always @(posedge clk) begin
        if (clrVisB) for (int i = 0; i < 256; i++) visB[i] <= 1'b0;
        else if (wrB) visB[addrB] <= 1'b1;
        if (rdB) rdataB <= wallB[addrB] | visB[addrB];
        if ((pushB && popB) || (rdB && wrB)) violB <= violB + 1;
        if (clrCntB) begin
            pushCntB <= 0; popCntB <= 0;
        end else begin
            if (pushB) pushCntB <= pushCntB + 1;
            if (popB) popCntB <= popCntB + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expSteps(input int n);
        return STEP_EN ? 32'(n) : 32'd0;
    endfunction

    // Clear walls and visited bits and the counters of instance A
    task automatic prepA();
        for (int i = 0; i < 256; i++) wallA[i] = 1'b0;
        @(negedge clk);
        clrVisA = 1'b1; clrCntA = 1'b1;
        @(negedge clk);
        clrVisA = 1'b0; clrCntA = 1'b0;
    endtask

    task automatic pulseA();
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
    endtask

    task automatic waitA(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (doneA || failA) break;
            @(negedge clk);
        end
        chk(tag, 32'(doneA || failA), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin wallA[i] = 1'b0; wallB[i] = 1'b0; end
        repeat (3) @(negedge clk);
        chk("rst_cur", 32'(curA), 32'h00);
        chk("rst_flags", 32'({busyA, doneA, failA, ovfA}), 32'd0);
        chk("rst_strobes", 32'({rdA, wrA, pushA, popA}), 32'd0);
        chk("rst_addr", 32'(addrA), 32'd0);
        chk("rst_steps", 32'(stepsA), 32'd0);
        rst = 1'b0;

        // Open grid, goal 03
        prepA();
        pulseA();
        chk("open_busy", 32'(busyA), 32'd1);
        waitA("open_to");
        chk("open_done", 32'({doneA, failA}), 32'b10);
        chk("open_cur", 32'(curA), 32'h03);
        chk("open_push", 32'(pushCntA), 32'd3);
        chk("open_stk", 32'({stkA[0], stkA[1], stkA[2]}), 32'h000102);
        chk("open_steps", 32'(stepsA), expSteps(3));
        chk("open_idle", 32'(busyA), 32'd0);

        // Start cell walled in; leftover stack is flushed first
        prepA();
        wallA[8'h01] = 1'b1; wallA[8'h10] = 1'b1;
        pulseA();
        waitA("wall_to");
        chk("wall_flags", 32'({doneA, failA, ovfA}), 32'b010);
        chk("wall_push", 32'(pushCntA), 32'd0);
        chk("wall_nempty", 32'(spA != 0), 32'd0);

        // Corridor down column 0 exceeds MAX_DEPTH = 4
        prepA();
        for (int r = 0; r < 6; r++) wallA[r*16 + 1] = 1'b1;
        pulseA();
        waitA("ovf_to");
        chk("ovf_flags", 32'({doneA, failA, ovfA}), 32'b011);
        chk("ovf_push", 32'(pushCntA), 32'd4);
        chk("ovf_cur", 32'(curA), 32'h40);
        chk("ovf_steps", 32'(stepsA), expSteps(4));

        // Preloaded stack of two entries is flushed before the first mark
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        prepA();
        tbPushA = 1'b1; tbDinA = 8'h55;
        @(negedge clk); tbDinA = 8'h66;
        @(negedge clk); tbPushA = 1'b0;
        chk("fl_pre", 32'(spA), 32'd2);
        pulseA();
        waitA("fl_to");
        chk("fl_pops", 32'(popsAtWrA), 32'd2);
        chk("fl_wraddr", 32'(wrAddrA), 32'h00);
        chk("fl_popall", 32'(popCntA), 32'd2);
        chk("fl_done", 32'({doneA, curA}), 32'h103);
        chk("fl_steps", 32'(stepsA), expSteps(3));

        // Dead end at 02 on instance B, backtrack to 01, then down to goal 11
        wallB[8'h03] = 1'b1; wallB[8'h12] = 1'b1;
        @(negedge clk); clrVisB = 1'b1; clrCntB = 1'b1;
        @(negedge clk); clrVisB = 1'b0; clrCntB = 1'b0;
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (doneB || failB) break;
            @(negedge clk);
        end
        chk("dead_flags", 32'({doneB, failB, ovfB}), 32'b100);
        chk("dead_cur", 32'(curB), 32'h11);
        chk("dead_push", 32'(pushCntB), 32'd3);
        chk("dead_pop", 32'(popCntB), 32'd1);
        chk("dead_steps", 32'(stepsB), expSteps(4));

        // Reset asserted while A waits on a RAM read
        prepA();
        pulseA();
        for (int i = 0; i < 100; i++) begin
            if (rdA) break;
            @(negedge clk);
        end
        chk("rw_rd", 32'(rdA), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("rw_cur", 32'(curA), 32'h00);
        chk("rw_flags", 32'({busyA, doneA, failA, ovfA}), 32'd0);
        chk("rw_strobes", 32'({rdA, wrA, pushA, popA}), 32'd0);
        chk("rw_addr_steps", 32'({addrA, stepsA}), 32'd0);
        chk("rw_stk", 32'(spA), 32'd0);
        @(negedge clk); rst = 1'b0;
        prepA();
        pulseA();
        waitA("rw2_to");
        chk("rw2_done", 32'({doneA, failA, curA}), 32'h203);
        chk("rw2_push", 32'(pushCntA), 32'd3);

        chk("excl_A", 32'(violA), 32'd0);
        chk("excl_B", 32'(violB), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
